// File: rtl/flp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (RNE, flush-to-zero) with valid/ready flow control.
// Optional exception flags output is enabled by defining FLP_MUL_FLAGS_EN.
module flp_mul_pipe #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EWIDTH+SWIDTH:0]   i_a,
  input  logic [EWIDTH+SWIDTH:0]   i_b,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [EWIDTH+SWIDTH:0]   o_p,
  output logic                     o_valid,
  input  logic                     i_ready
`ifdef FLP_MUL_FLAGS_EN
  ,
  output logic [3:0]               o_flags
`endif
);

  localparam int W    = EWIDTH + SWIDTH + 1;
  localparam int PW   = 2 * (SWIDTH + 1);
  localparam int XW   = EWIDTH + 2;
  localparam logic [XW-1:0]        BIAS = XW'((1 << (EWIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EWIDTH) - 1);

  // Flow control: a stage advances when empty or when the next stage advances.
  logic s1_valid, s2_valid;
  logic s3_adv, s2_adv;

  assign s3_adv  = !o_valid || i_ready;
  assign s2_adv  = !s2_valid || s3_adv;
  assign o_ready = !s1_valid || s2_adv;

  // ---------------- Stage 1: unpack and classify ----------------
  logic              a_sign, b_sign;
  logic [EWIDTH-1:0] a_exp, b_exp;
  logic [SWIDTH-1:0] a_frac, b_frac;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {a_sign, a_exp, a_frac} = i_a;
  assign {b_sign, b_exp, b_frac} = i_b;
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);

  logic              s1_sign, s1_nan, s1_inf, s1_zero;
  logic [XW-1:0]     s1_exp;
  logic [SWIDTH:0]   s1_ma, s1_mb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sign <= a_sign ^ b_sign;
        s1_nan  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        s1_inf  <= a_inf || b_inf;
        s1_zero <= a_zero || b_zero;
        s1_exp  <= {2'b00, a_exp} + {2'b00, b_exp} - BIAS;
        s1_ma   <= {1'b1, a_frac};
        s1_mb   <= {1'b1, b_frac};
      end
    end
  end

  // ---------------- Stage 2: significand product ----------------
  logic              s2_sign, s2_nan, s2_inf, s2_zero;
  logic [XW-1:0]     s2_exp;
  logic [PW-1:0]     s2_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
        s2_exp  <= s1_exp;
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      end
    end
  end

  // ---------------- Stage 3: normalise, round, pack ----------------
  // Product lies in [1,4); drop the leading one and left-align so the
  // fraction always sits at the same bit positions.
  logic                     top;
  logic [PW-2:0]            pn;
  logic [SWIDTH-1:0]        mant;
  logic [RSWIDTH-1:0]       guard;
  logic                     sticky, round_up;
  logic [SWIDTH:0]          frac_sum;
  logic signed [XW-1:0]     exp_n, exp_r;
  logic                     ovf, unf;

  assign top      = s2_prod[PW-1];
  assign pn       = top ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
  assign mant     = pn[2*SWIDTH -: SWIDTH];
  assign guard    = pn[SWIDTH -: RSWIDTH];
  assign sticky   = |pn[SWIDTH-RSWIDTH:0];
  assign round_up = guard[RSWIDTH-1] && ((|guard[RSWIDTH-2:0]) || sticky || mant[0]);
  assign frac_sum = {1'b0, mant} + (SWIDTH+1)'(round_up);
  assign exp_n    = s2_exp + XW'(top);
  assign exp_r    = exp_n + XW'(frac_sum[SWIDTH]);
  assign ovf      = (exp_r >= EMAX);
  assign unf      = (exp_r <= 0);

  logic [W-1:0] p_next;

  always_comb begin
    p_next = {s2_sign, exp_r[EWIDTH-1:0], frac_sum[SWIDTH-1:0]};
    if (s2_nan)
      p_next = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
    else if (s2_inf || (!s2_zero && ovf))
      p_next = {s2_sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
    else if (s2_zero || unf)
      p_next = {s2_sign, {(W-1){1'b0}}};
  end

`ifdef FLP_MUL_FLAGS_EN
  logic [3:0] flags_next;

  always_comb begin
    flags_next = {3'b000, (|guard) || sticky};
    if (s2_nan)
      flags_next = 4'b1000;
    else if (s2_inf || s2_zero)
      flags_next = 4'b0000;
    else if (ovf)
      flags_next = 4'b0101;
    else if (unf)
      flags_next = 4'b0011;
  end

  always_ff @(posedge clk) begin
    if (rst)
      o_flags <= 4'b0000;
    else if (s3_adv && s2_valid)
      o_flags <= flags_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_p     <= '0;
    end else if (s3_adv) begin
      o_valid <= s2_valid;
      if (s2_valid)
        o_p <= p_next;
    end
  end

endmodule
